// File: rtl/icache_refill_pkg.sv
// ----------------------------------------------------------------------------
// icache_refill_pkg
//   Shared definitions for the instruction-cache refill router:
//   - default geometry used by the router and its address decoder
//   - refill FSM state encoding
//   - helpers deriving the line-offset width and the timeout counter width
// ----------------------------------------------------------------------------
package icache_refill_pkg;

    localparam int DEF_PHY_ADDR_SIZE   = 40;
    localparam int DEF_FETCH_WIDTH     = 128;
    localparam int DEF_BROM_ADDR_WIDTH = 24;
    localparam int DEF_TIMEOUT_CYCLES  = 1024;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BROM_REQ  = 3'd1,
        ST_BROM_WAIT = 3'd2,
        ST_L2_WAIT   = 3'd3,
        ST_DRAIN     = 3'd4
    } refill_state_e;

    // Number of byte-offset bits inside one refill line.
    function automatic int offset_bits(input int fetch_width);
        return $clog2(fetch_width / 8);
    endfunction

    // Width of the wait-cycle counter; it only ever counts up to
    // timeout_cycles-1, so $clog2 is enough (clamped to one bit).
    function automatic int timer_width(input int timeout_cycles);
        return (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    endfunction

endpackage

// File: rtl/refill_addr_decode.sv
// ----------------------------------------------------------------------------
// refill_addr_decode
//   Purely combinational address decode for a refill request.
//   Ports:
//     paddr_i      refill physical byte address
//     line_addr_o  address aligned to the refill line (offset bits zeroed)
//     brom_hit_o   line address lies inside [BROM_BASE, BROM_BASE+BROM_SIZE)
//     brom_addr_o  bootrom-relative line address (line - BROM_BASE, truncated)
// ----------------------------------------------------------------------------
module refill_addr_decode
    import icache_refill_pkg::*;
#(
    parameter int                       PHY_ADDR_SIZE   = DEF_PHY_ADDR_SIZE,
    parameter int                       FETCH_WIDTH     = DEF_FETCH_WIDTH,
    parameter logic [PHY_ADDR_SIZE-1:0] BROM_BASE       = '0,
    parameter logic [PHY_ADDR_SIZE-1:0] BROM_SIZE       = PHY_ADDR_SIZE'('h10000),
    parameter int                       BROM_ADDR_WIDTH = DEF_BROM_ADDR_WIDTH
) (
    input  logic [PHY_ADDR_SIZE-1:0]   paddr_i,
    output logic [PHY_ADDR_SIZE-1:0]   line_addr_o,
    output logic                       brom_hit_o,
    output logic [BROM_ADDR_WIDTH-1:0] brom_addr_o
);

    localparam int OFFSET_BITS = offset_bits(FETCH_WIDTH);
    localparam logic [PHY_ADDR_SIZE-1:0] OFFSET_MASK =
        PHY_ADDR_SIZE'((64'd1 << OFFSET_BITS) - 64'd1);

    // One extra bit so that "line below base" shows up as a borrow instead of
    // wrapping into a large in-range-looking offset.
    logic [PHY_ADDR_SIZE:0] rel_addr;

    assign line_addr_o = paddr_i & ~OFFSET_MASK;
    assign rel_addr    = {1'b0, line_addr_o} - {1'b0, BROM_BASE};

    // Hit when no borrow and the offset from the base is below the size.
    assign brom_hit_o  = !rel_addr[PHY_ADDR_SIZE] &&
                         (rel_addr[PHY_ADDR_SIZE-1:0] < BROM_SIZE);
    assign brom_addr_o = rel_addr[BROM_ADDR_WIDTH-1:0];

endmodule

// File: rtl/icache_refill_router.sv
// ----------------------------------------------------------------------------
// icache_refill_router
//   Routes instruction-cache line refills to either the bootrom or the L2,
//   returns one registered grant per accepted request, and converts a source
//   that never answers into an error grant after TIMEOUT_CYCLES wait cycles.
//   A kill abandons the in-flight refill: the owed response (or a timeout) is
//   drained silently before the next request is accepted.
//
//   Ports:
//     clk_i, rstn_i          clock, asynchronous active-low reset
//     ic_req_valid_i/paddr_i refill request (held by the core until grant)
//     ic_kill_i              abandon the in-flight refill
//     ic_resp_valid_o        one-cycle grant pulse
//     ic_resp_data_o         grant line (holds its value between grants)
//     ic_resp_error_o        grant is a timeout error
//     brom_req_*_o / brom_ready_i / brom_resp_*_i   bootrom valid/ready port
//     l2_req_*_o / l2_resp_*_i                      L2 pulse request port
// ----------------------------------------------------------------------------
module icache_refill_router
    import icache_refill_pkg::*;
#(
    parameter int                       PHY_ADDR_SIZE   = DEF_PHY_ADDR_SIZE,
    parameter int                       FETCH_WIDTH     = DEF_FETCH_WIDTH,
    parameter logic [PHY_ADDR_SIZE-1:0] BROM_BASE       = '0,
    parameter logic [PHY_ADDR_SIZE-1:0] BROM_SIZE       = PHY_ADDR_SIZE'('h10000),
    parameter int                       BROM_ADDR_WIDTH = DEF_BROM_ADDR_WIDTH,
    parameter int                       TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    // core refill port
    input  logic                       ic_req_valid_i,
    input  logic [PHY_ADDR_SIZE-1:0]   ic_req_paddr_i,
    input  logic                       ic_kill_i,
    output logic                       ic_resp_valid_o,
    output logic [FETCH_WIDTH-1:0]     ic_resp_data_o,
    output logic                       ic_resp_error_o,
    // bootrom port
    output logic                       brom_req_valid_o,
    output logic [BROM_ADDR_WIDTH-1:0] brom_req_address_o,
    input  logic                       brom_ready_i,
    input  logic                       brom_resp_valid_i,
    input  logic [FETCH_WIDTH-1:0]     brom_resp_data_i,
    // L2 port
    output logic                       l2_req_valid_o,
    output logic [PHY_ADDR_SIZE-1:0]   l2_req_paddr_o,
    input  logic                       l2_resp_valid_i,
    input  logic [FETCH_WIDTH-1:0]     l2_resp_data_i
);

    localparam int TIMER_W = timer_width(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Address decode of the incoming request
    // ------------------------------------------------------------------------
    logic [PHY_ADDR_SIZE-1:0]   dec_line_addr;
    logic                       dec_brom_hit;
    logic [BROM_ADDR_WIDTH-1:0] dec_brom_addr;

    refill_addr_decode #(
        .PHY_ADDR_SIZE   (PHY_ADDR_SIZE),
        .FETCH_WIDTH     (FETCH_WIDTH),
        .BROM_BASE       (BROM_BASE),
        .BROM_SIZE       (BROM_SIZE),
        .BROM_ADDR_WIDTH (BROM_ADDR_WIDTH)
    ) u_decode (
        .paddr_i     (ic_req_paddr_i),
        .line_addr_o (dec_line_addr),
        .brom_hit_o  (dec_brom_hit),
        .brom_addr_o (dec_brom_addr)
    );

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    refill_state_e              state_q, state_d;
    logic [TIMER_W-1:0]         timer_q, timer_d;
    logic [PHY_ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [BROM_ADDR_WIDTH-1:0] brom_addr_q, brom_addr_d;
    logic                       src_brom_q, src_brom_d;   // source owing the response
    logic                       kill_pend_q, kill_pend_d; // kill seen during BROM_REQ
    logic                       l2_req_valid_q, l2_req_valid_d;
    logic                       resp_valid_q, resp_valid_d;
    logic                       resp_error_q, resp_error_d;
    logic [FETCH_WIDTH-1:0]     resp_data_q, resp_data_d;

    // Only the source that was actually asked is ever listened to.
    logic                       sel_resp_valid;
    logic [FETCH_WIDTH-1:0]     sel_resp_data;
    logic                       timed_out;

    assign sel_resp_valid = src_brom_q ? brom_resp_valid_i : l2_resp_valid_i;
    assign sel_resp_data  = src_brom_q ? brom_resp_data_i  : l2_resp_data_i;
    assign timed_out      = (timer_q == TIMER_LAST);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            addr_q         <= '0;
            brom_addr_q    <= '0;
            src_brom_q     <= 1'b0;
            kill_pend_q    <= 1'b0;
            l2_req_valid_q <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_error_q   <= 1'b0;
            resp_data_q    <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            addr_q         <= addr_d;
            brom_addr_q    <= brom_addr_d;
            src_brom_q     <= src_brom_d;
            kill_pend_q    <= kill_pend_d;
            l2_req_valid_q <= l2_req_valid_d;
            resp_valid_q   <= resp_valid_d;
            resp_error_q   <= resp_error_d;
            resp_data_q    <= resp_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q + TIMER_W'(1);
        addr_d         = addr_q;
        brom_addr_d    = brom_addr_q;
        src_brom_d     = src_brom_q;
        kill_pend_d    = kill_pend_q;
        l2_req_valid_d = 1'b0;
        resp_valid_d   = 1'b0;
        resp_error_d   = 1'b0;
        resp_data_d    = resp_data_q;

        unique case (state_q)
            ST_IDLE: begin
                timer_d     = '0;
                kill_pend_d = 1'b0;
                // A request still held during its own grant cycle must not be
                // accepted a second time, hence the resp_valid_q term.
                if (ic_req_valid_i && !ic_kill_i && !resp_valid_q) begin
                    addr_d = dec_line_addr;
                    if (dec_brom_hit) begin
                        brom_addr_d = dec_brom_addr;
                        src_brom_d  = 1'b1;
                        state_d     = ST_BROM_REQ;
                    end else begin
                        src_brom_d     = 1'b0;
                        l2_req_valid_d = 1'b1;
                        state_d        = ST_L2_WAIT;
                    end
                end
            end

            ST_BROM_REQ: begin
                // A kill here cannot withdraw the request; remember it and
                // finish the handshake first.
                if (ic_kill_i) begin
                    kill_pend_d = 1'b1;
                end
                if (brom_ready_i) begin
                    timer_d = '0;
                    state_d = (ic_kill_i || kill_pend_q) ? ST_DRAIN : ST_BROM_WAIT;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                    if (!(ic_kill_i || kill_pend_q)) begin
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_data_d  = '0;
                    end
                end
            end

            ST_BROM_WAIT, ST_L2_WAIT: begin
                if (sel_resp_valid) begin
                    // A response beats a simultaneous timeout; a simultaneous
                    // kill discards it.
                    state_d = ST_IDLE;
                    if (!ic_kill_i) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = sel_resp_data;
                    end
                end else if (ic_kill_i) begin
                    timer_d = '0;
                    state_d = ST_DRAIN;
                end else if (timed_out) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                    resp_data_d  = '0;
                end
            end

            ST_DRAIN: begin
                // Swallow the owed response (or give up on it) silently.
                if (sel_resp_valid || timed_out) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ic_resp_valid_o    = resp_valid_q;
    assign ic_resp_data_o     = resp_data_q;
    assign ic_resp_error_o    = resp_error_q;
    assign brom_req_valid_o   = (state_q == ST_BROM_REQ);
    assign brom_req_address_o = brom_addr_q;
    assign l2_req_valid_o     = l2_req_valid_q;
    assign l2_req_paddr_o     = addr_q;

endmodule

// File: tb/tb_icache_refill_router.sv
// ----------------------------------------------------------------------------
// tb_icache_refill_router
//   Directed stimulus for the refill router. A transaction-level reference
//   (busy / handshake-done / killed flags, an age count and an expected grant)
//   predicts the outputs every cycle; a negedge process compares them, and
//   the directed sequences add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_icache_refill_router;

    localparam int PA  = 40;
    localparam int FW  = 128;
    localparam int BAW = 24;
    localparam int TO  = 16;
    localparam logic [63:0] BASE = 64'h0;
    localparam logic [63:0] SIZE = 64'h10000;

    logic           clk_i = 1'b0;
    logic           rstn_i = 1'b0;
    logic           ic_req_valid_i = 1'b0;
    logic [PA-1:0]  ic_req_paddr_i = '0;
    logic           ic_kill_i = 1'b0;
    logic           ic_resp_valid_o;
    logic [FW-1:0]  ic_resp_data_o;
    logic           ic_resp_error_o;
    logic           brom_req_valid_o;
    logic [BAW-1:0] brom_req_address_o;
    logic           brom_ready_i = 1'b0;
    logic           brom_resp_valid_i = 1'b0;
    logic [FW-1:0]  brom_resp_data_i = '0;
    logic           l2_req_valid_o;
    logic [PA-1:0]  l2_req_paddr_o;
    logic           l2_resp_valid_i = 1'b0;
    logic [FW-1:0]  l2_resp_data_i = '0;

    always #5 clk_i = ~clk_i;

    icache_refill_router #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .ic_req_valid_i     (ic_req_valid_i),
        .ic_req_paddr_i     (ic_req_paddr_i),
        .ic_kill_i          (ic_kill_i),
        .ic_resp_valid_o    (ic_resp_valid_o),
        .ic_resp_data_o     (ic_resp_data_o),
        .ic_resp_error_o    (ic_resp_error_o),
        .brom_req_valid_o   (brom_req_valid_o),
        .brom_req_address_o (brom_req_address_o),
        .brom_ready_i       (brom_ready_i),
        .brom_resp_valid_i  (brom_resp_valid_i),
        .brom_resp_data_i   (brom_resp_data_i),
        .l2_req_valid_o     (l2_req_valid_o),
        .l2_req_paddr_o     (l2_req_paddr_o),
        .l2_resp_valid_i    (l2_resp_valid_i),
        .l2_resp_data_i     (l2_resp_data_i)
    );

    int checks = 0;
    int errors = 0;
    int grant_cnt = 0;
    int l2_pulses = 0;
    int brom_cycles = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: one outstanding refill described by a few flags.
    // ------------------------------------------------------------------------
    logic          m_busy, m_shaken, m_killed, m_to_brom;
    int            m_age;
    logic [PA-1:0] m_line;
    logic          m_rv, m_err, m_l2v;
    logic [FW-1:0] m_data;

    logic          n_busy, n_shaken, n_killed, n_to_brom;
    int            n_age;
    logic [PA-1:0] n_line;
    logic          n_rv, n_err, n_l2v;
    logic [FW-1:0] n_data;

    logic          m_rsp;
    logic [FW-1:0] m_rsp_data;
    logic          m_bromv;
    logic [BAW-1:0] m_brom_rel;
    logic [63:0]   m_rel64;

    assign m_rsp      = m_to_brom ? brom_resp_valid_i : l2_resp_valid_i;
    assign m_rsp_data = m_to_brom ? brom_resp_data_i : l2_resp_data_i;
    assign m_bromv    = m_busy && m_to_brom && !m_shaken;
    assign m_rel64    = {24'h0, m_line} - BASE;
    assign m_brom_rel = m_rel64[BAW-1:0];

    function automatic logic in_brom(input logic [PA-1:0] line);
        logic [63:0] off;
        off = {24'h0, line} - BASE;  // wraps huge when below the base
        return off < SIZE;
    endfunction

    always_comb begin
        n_busy    = m_busy;
        n_shaken  = m_shaken;
        n_killed  = m_killed;
        n_to_brom = m_to_brom;
        n_age     = m_age + 1;
        n_line    = m_line;
        n_rv      = 1'b0;
        n_err     = 1'b0;
        n_l2v     = 1'b0;
        n_data    = m_data;
        if (!m_busy) begin
            n_age = 0;
            if (ic_req_valid_i && !ic_kill_i && !m_rv) begin
                n_busy   = 1'b1;
                n_killed = 1'b0;
                n_line   = {ic_req_paddr_i[PA-1:4], 4'h0};
                if (in_brom(n_line)) begin
                    n_to_brom = 1'b1;
                    n_shaken  = 1'b0;
                end else begin
                    n_to_brom = 1'b0;
                    n_shaken  = 1'b1;
                    n_l2v     = 1'b1;
                end
            end
        end else if (!m_shaken) begin
            if (ic_kill_i) n_killed = 1'b1;
            if (brom_ready_i) begin
                n_shaken = 1'b1;
                n_age    = 0;
            end else if (m_age == TO - 1) begin
                n_busy = 1'b0;
                if (!(m_killed || ic_kill_i)) begin
                    n_rv = 1'b1; n_err = 1'b1; n_data = '0;
                end
            end
        end else if (m_killed) begin
            if (m_rsp || m_age == TO - 1) n_busy = 1'b0;
        end else begin
            if (m_rsp) begin
                n_busy = 1'b0;
                if (!ic_kill_i) begin
                    n_rv = 1'b1; n_data = m_rsp_data;
                end
            end else if (ic_kill_i) begin
                n_killed = 1'b1;
                n_age    = 0;
            end else if (m_age == TO - 1) begin
                n_busy = 1'b0;
                n_rv = 1'b1; n_err = 1'b1; n_data = '0;
            end
        end
    end

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            m_busy <= 1'b0; m_shaken <= 1'b0; m_killed <= 1'b0; m_to_brom <= 1'b0;
            m_age <= 0; m_line <= '0; m_rv <= 1'b0; m_err <= 1'b0; m_l2v <= 1'b0;
            m_data <= '0;
        end else begin
            m_busy <= n_busy; m_shaken <= n_shaken; m_killed <= n_killed;
            m_to_brom <= n_to_brom; m_age <= n_age; m_line <= n_line;
            m_rv <= n_rv; m_err <= n_err; m_l2v <= n_l2v; m_data <= n_data;
        end
    end

    // Per-cycle comparison and event counting, away from the active edge.
    always @(negedge clk_i) begin
        chk("cyc_resp_valid", ic_resp_valid_o, m_rv);
        chk("cyc_resp_error", ic_resp_error_o, m_err);
        chk("cyc_resp_data", ic_resp_data_o, m_data);
        chk("cyc_l2_valid", l2_req_valid_o, m_l2v);
        chk("cyc_brom_valid", brom_req_valid_o, m_bromv);
        if (m_l2v) chk("cyc_l2_paddr", l2_req_paddr_o, m_line);
        if (m_bromv) chk("cyc_brom_addr", brom_req_address_o, m_brom_rel);
        if (ic_resp_valid_o) grant_cnt++;
        if (l2_req_valid_o) l2_pulses++;
        if (brom_req_valid_o) brom_cycles++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Directed sequences
    // ------------------------------------------------------------------------
    initial begin
        int g0;
        int p0;
        int b0;
        logic [FW-1:0] pat_a5;
        pat_a5 = {16{8'hA5}};

        // reset
        tick(); tick();
        chk("reset_resp_valid", ic_resp_valid_o, 0);
        chk("reset_resp_data", ic_resp_data_o, 0);
        chk("reset_brom_valid", brom_req_valid_o, 0);
        chk("reset_l2_valid", l2_req_valid_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick();

        // bootrom fetch
        g0 = grant_cnt;
        ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h108;
        tick();
        chk("brom_req_valid", brom_req_valid_o, 1);
        chk("brom_req_addr", brom_req_address_o, 24'h100);
        tick();
        chk("brom_req_hold", brom_req_valid_o, 1);
        chk("brom_req_addr_hold", brom_req_address_o, 24'h100);
        brom_ready_i = 1'b1;
        tick();
        brom_ready_i = 1'b0;
        chk("brom_req_drop", brom_req_valid_o, 0);
        tick(); tick();
        brom_resp_valid_i = 1'b1; brom_resp_data_i = pat_a5;
        tick();
        brom_resp_valid_i = 1'b0; brom_resp_data_i = '0;
        chk("brom_grant_valid", ic_resp_valid_o, 1);
        chk("brom_grant_data", ic_resp_data_o, pat_a5);
        chk("brom_grant_error", ic_resp_error_o, 0);
        ic_req_valid_i = 1'b0;
        tick();
        chk("brom_grant_once", grant_cnt - g0, 1);
        chk("brom_data_held", ic_resp_data_o, pat_a5);

        // L2 fetch
        g0 = grant_cnt; p0 = l2_pulses; b0 = brom_cycles;
        ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h80_0000_47;
        ic_req_paddr_i = 40'h8000_0047;
        tick();
        chk("l2_req_valid", l2_req_valid_o, 1);
        chk("l2_req_paddr", l2_req_paddr_o, 40'h8000_0040);
        tick();
        chk("l2_req_pulse_end", l2_req_valid_o, 0);
        tick(); tick(); tick();
        l2_resp_valid_i = 1'b1; l2_resp_data_i = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        tick();
        l2_resp_valid_i = 1'b0;
        chk("l2_grant_valid", ic_resp_valid_o, 1);
        chk("l2_grant_data", ic_resp_data_o, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
        ic_req_valid_i = 1'b0;
        tick();
        chk("l2_one_pulse", l2_pulses - p0, 1);
        chk("l2_no_brom", brom_cycles - b0, 0);
        chk("l2_grant_once", grant_cnt - g0, 1);

        // held request through the grant cycle
        p0 = l2_pulses;
        ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h40_0000_0010;
        tick();
        tick();
        l2_resp_valid_i = 1'b1; l2_resp_data_i = 128'h1111;
        tick();
        l2_resp_valid_i = 1'b0;
        chk("held_grant", ic_resp_valid_o, 1);
        chk("held_no_pulse_in_grant", l2_req_valid_o, 0);
        tick();
        chk("held_no_pulse_after", l2_req_valid_o, 0);
        tick();
        chk("held_reaccept_pulse", l2_req_valid_o, 1);
        ic_req_valid_i = 1'b0;
        l2_resp_valid_i = 1'b1; l2_resp_data_i = 128'h2222;
        tick();
        l2_resp_valid_i = 1'b0;
        chk("held_second_grant", ic_resp_data_o, 128'h2222);
        tick();
        chk("held_two_pulses", l2_pulses - p0, 2);

        // timeout: L2 never answers
        g0 = grant_cnt;
        ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h90_0000_0000;
        tick();  // first L2_WAIT cycle
        for (int i = 0; i < 15; i++) tick();
        chk("to_not_yet", ic_resp_valid_o, 0);
        tick();  // 16 cycles after entering L2_WAIT
        chk("to_grant_valid", ic_resp_valid_o, 1);
        chk("to_grant_error", ic_resp_error_o, 1);
        chk("to_grant_data", ic_resp_data_o, 0);
        ic_req_valid_i = 1'b0;
        tick();
        l2_resp_valid_i = 1'b1; l2_resp_data_i = 128'hDEAD;
        tick();
        l2_resp_valid_i = 1'b0;
        tick();
        chk("to_late_ignored", grant_cnt - g0, 1);

        // kill during L2_WAIT, then a bootrom request
        g0 = grant_cnt;
        ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'hA0_0000_0000;
        tick();
        tick();
        ic_kill_i = 1'b1; ic_req_valid_i = 1'b0;
        tick();
        ic_kill_i = 1'b0;
        ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h200;
        chk("kill_drain_1", brom_req_valid_o, 0);
        tick();
        chk("kill_drain_2", brom_req_valid_o, 0);
        tick();
        chk("kill_drain_3", brom_req_valid_o, 0);
        l2_resp_valid_i = 1'b1; l2_resp_data_i = 128'hBAD;
        tick();
        l2_resp_valid_i = 1'b0;
        chk("kill_no_grant", ic_resp_valid_o, 0);
        chk("kill_idle_no_brom", brom_req_valid_o, 0);
        tick();
        chk("kill_new_brom_valid", brom_req_valid_o, 1);
        chk("kill_new_brom_addr", brom_req_address_o, 24'h200);
        brom_ready_i = 1'b1;
        tick();
        brom_ready_i = 1'b0;
        brom_resp_valid_i = 1'b1; brom_resp_data_i = 128'h200200;
        tick();
        brom_resp_valid_i = 1'b0;
        chk("kill_new_grant_data", ic_resp_data_o, 128'h200200);
        ic_req_valid_i = 1'b0;
        tick();
        chk("kill_grant_count", grant_cnt - g0, 1);

        // boundaries
        p0 = l2_pulses;
        ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'hFFF0;
        tick();
        chk("bnd_fff0_brom", brom_req_valid_o, 1);
        chk("bnd_fff0_addr", brom_req_address_o, 24'hFFF0);
        chk("bnd_fff0_no_l2", l2_req_valid_o, 0);
        brom_ready_i = 1'b1;
        tick();
        brom_ready_i = 1'b0;
        brom_resp_valid_i = 1'b1; brom_resp_data_i = 128'hF0F0;
        tick();
        brom_resp_valid_i = 1'b0;
        chk("bnd_fff0_grant", ic_resp_valid_o, 1);
        ic_req_valid_i = 1'b0;
        tick();
        ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h1_0000;
        tick();
        chk("bnd_10000_l2", l2_req_valid_o, 1);
        chk("bnd_10000_paddr", l2_req_paddr_o, 40'h1_0000);
        chk("bnd_10000_no_brom", brom_req_valid_o, 0);
        tick();
        l2_resp_valid_i = 1'b1; l2_resp_data_i = 128'h7777;
        tick();
        l2_resp_valid_i = 1'b0;
        chk("bnd_10000_grant", ic_resp_data_o, 128'h7777);
        ic_req_valid_i = 1'b0;
        tick();
        chk("bnd_pulses", l2_pulses - p0, 1);

        // reset while waiting on the bootrom
        g0 = grant_cnt;
        ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h20;
        tick();
        brom_ready_i = 1'b1;
        tick();
        brom_ready_i = 1'b0;
        rstn_i = 1'b0;
        #1;
        chk("rst_resp_valid", ic_resp_valid_o, 0);
        chk("rst_resp_data", ic_resp_data_o, 0);
        chk("rst_brom_valid", brom_req_valid_o, 0);
        chk("rst_l2_valid", l2_req_valid_o, 0);
        chk("rst_l2_paddr", l2_req_paddr_o, 0);
        ic_req_valid_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick();
        brom_resp_valid_i = 1'b1; brom_resp_data_i = 128'h5555;
        tick();
        brom_resp_valid_i = 1'b0;
        chk("rst_stray_no_grant", ic_resp_valid_o, 0);
        tick();
        chk("rst_grant_count", grant_cnt - g0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
